i2s_audio_tx: RTL and testbench



---
 rtl/i2s_audio_tx.sv | 175 +++++++++++++++++
 tb/tb_i2s_audio_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_audio_tx.sv
// I2S transmitter: single-buffered stereo PCM in, bclk/lrclk/sdata out.
// Runs only while the audio PLL reports lock; flushes to idle otherwise.
module i2s_audio_tx #(
    parameter int CLKS_PER_BCLK = 6,
    parameter int SLOT_W        = 32,
    parameter int DATA_W        = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              frame_start,
    output logic              underrun,
    output logic [15:0]       underrun_cnt
);

    localparam int FW  = 2 * SLOT_W;
    localparam int CCW = $clog2(CLKS_PER_BCLK);
    localparam int BCW = $clog2(FW);

    localparam logic [CCW-1:0] CC_LAST = CCW'(CLKS_PER_BCLK - 1);
    localparam logic [CCW-1:0] CC_HALF = CCW'(CLKS_PER_BCLK / 2);
    localparam logic [BCW-1:0] BC_LAST = BCW'(FW - 1);
    localparam logic [BCW-1:0] BC_SLOT = BCW'(SLOT_W);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e state_q, state_d;

    logic [CCW-1:0]    ccnt_q, ccnt_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic              bclk_q, bclk_d;
    logic              lrclk_q, lrclk_d;
    logic [FW-1:0]     shift_q, shift_d;
    logic              full_q, full_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d;
    logic [DATA_W-1:0] hold_r_q, hold_r_d;
    logic              ready_q, ready_d;
    logic              fstart_q, fstart_d;
    logic              urun_q, urun_d;
    logic [15:0]       urun_cnt_q, urun_cnt_d;

    logic              run;
    logic              accept;
    logic              fe;
    logic              load;
    logic [SLOT_W-1:0] l_slot;
    logic [SLOT_W-1:0] r_slot;

    // run is true only when the block stays in RUN across this edge
    assign run    = (state_q == RUN) && pll_locked;
    assign accept = s_valid && ready_q;
    assign fe     = run && (ccnt_q == CC_LAST);
    assign load   = fe && (bit_cnt_q == '0);

    assign l_slot = SLOT_W'(hold_l_q) << (SLOT_W - DATA_W);
    assign r_slot = SLOT_W'(hold_r_q) << (SLOT_W - DATA_W);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pll_locked) state_d = RUN;
            RUN:     if (!pll_locked) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ccnt_d     = '0;
        bit_cnt_d  = '0;
        bclk_d     = 1'b0;
        lrclk_d    = 1'b0;
        shift_d    = '0;
        full_d     = 1'b0;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        ready_d    = 1'b0;
        fstart_d   = 1'b0;
        urun_d     = 1'b0;
        urun_cnt_d = urun_cnt_q;

        if (run) begin
            ccnt_d    = fe ? '0 : ccnt_q + 1'b1;
            bit_cnt_d = bit_cnt_q;
            shift_d   = shift_q;
            full_d    = full_q;

            if (fe) begin
                bit_cnt_d = (bit_cnt_q == BC_LAST) ? '0 : bit_cnt_q + 1'b1;
                shift_d   = {shift_q[FW-2:0], 1'b0};
            end

            if (load) begin
                fstart_d = 1'b1;
                if (full_q) begin
                    shift_d = {l_slot, r_slot};
                end else begin
                    shift_d = '0;
                    urun_d  = 1'b1;
                    if (urun_cnt_q != 16'hFFFF) begin
                        urun_cnt_d = urun_cnt_q + 16'd1;
                    end
                end
                full_d = 1'b0;
            end

            // a same-edge accept lands after the load: no bypass
            if (accept) begin
                full_d   = 1'b1;
                hold_l_d = s_left;
                hold_r_d = s_right;
            end

            ready_d = !full_q && !accept;
            bclk_d  = (ccnt_d >= CC_HALF);
            lrclk_d = (bit_cnt_d >= BC_SLOT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ccnt_q     <= '0;
            bit_cnt_q  <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            shift_q    <= '0;
            full_q     <= 1'b0;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            ready_q    <= 1'b0;
            fstart_q   <= 1'b0;
            urun_q     <= 1'b0;
            urun_cnt_q <= '0;
        end else begin
            ccnt_q     <= ccnt_d;
            bit_cnt_q  <= bit_cnt_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            shift_q    <= shift_d;
            full_q     <= full_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            ready_q    <= ready_d;
            fstart_q   <= fstart_d;
            urun_q     <= urun_d;
            urun_cnt_q <= urun_cnt_d;
        end
    end

    assign s_ready      = ready_q;
    assign bclk         = bclk_q;
    assign lrclk        = lrclk_q;
    assign sdata        = shift_q[FW-1];
    assign frame_start  = fstart_q;
    assign underrun     = urun_q;
    assign underrun_cnt = urun_cnt_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Randomized bench for i2s_audio_tx against a time-indexed frame model.
// Covers reset, single frame, underrun, backpressure, lock loss, saturation.
module tb_i2s_audio_tx;

    localparam int C = 6;
    localparam int S = 32;
    localparam int D = 24;
    localparam int FRAME = 2 * S * C;

    localparam int M_IDLE = 0;
    localparam int M_RAND = 1;
    localparam int M_ALL  = 2;
    localparam int M_FIX  = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pll_locked;
    logic         s_valid;
    logic         s_ready;
    logic [D-1:0] s_left;
    logic [D-1:0] s_right;
    logic         bclk;
    logic         lrclk;
    logic         sdata;
    logic         frame_start;
    logic         underrun;
    logic [15:0]  underrun_cnt;

    int n_run  = 0;
    int n_fail = 0;

    bit             m_known = 1'b0;
    bit             m_run = 1'b0;
    bit             m_full = 1'b0;
    bit             m_ready = 1'b0;
    bit             m_fs = 1'b0;
    bit             m_ur = 1'b0;
    bit             m_loaded = 1'b0;
    bit             fixed_done = 1'b0;
    int             t = 0;
    int             m_ucnt = 0;
    int             m_load_fe = 0;
    logic [D-1:0]   m_hl = '0;
    logic [D-1:0]   m_hr = '0;
    logic [2*S-1:0] m_frame = '0;

    bit drv_rst = 1'b0;
    bit drv_pll = 1'b1;
    int mode = M_IDLE;

    i2s_audio_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_left       (s_left),
        .s_right      (s_right),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic step();
        bit   acc;
        bit   ld;
        bit   nready;
        bit   e_sd;
        int   nt;
        int   p;
        int   bc;
        @(posedge clk);
        #1;
        if (m_known) begin
            bc   = (t / C) % (2 * S);
            e_sd = 1'b0;
            if (m_run && m_loaded) begin
                p    = t / C - m_load_fe;
                e_sd = m_frame[2*S-1-p];
            end
            chk("bclk", 32'(bclk), 32'(m_run && ((t % C) >= C / 2)));
            chk("lrclk", 32'(lrclk), 32'(m_run && (bc >= S)));
            chk("sdata", 32'(sdata), 32'(e_sd));
            chk("s_ready", 32'(s_ready), 32'(m_ready));
            chk("frame_start", 32'(frame_start), 32'(m_fs));
            chk("underrun", 32'(underrun), 32'(m_ur));
            chk("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
        end

        rst_n      = drv_rst;
        pll_locked = drv_pll;
        s_left     = D'($urandom);
        s_right    = D'($urandom);
        case (mode)
            M_IDLE:  s_valid = 1'b0;
            M_RAND:  s_valid = 1'($urandom_range(0, 1));
            M_ALL:   s_valid = 1'b1;
            default: begin
                s_valid = !fixed_done;
                s_left  = 24'hA5A5A5;
                s_right = 24'h5A5A5A;
            end
        endcase

        if (!rst_n) begin
            m_known  = 1'b1;
            m_run    = 1'b0;
            m_full   = 1'b0;
            m_ready  = 1'b0;
            m_fs     = 1'b0;
            m_ur     = 1'b0;
            m_loaded = 1'b0;
            m_ucnt   = 0;
            t        = 0;
        end else if (!m_run || !pll_locked) begin
            m_full   = 1'b0;
            m_ready  = 1'b0;
            m_fs     = 1'b0;
            m_ur     = 1'b0;
            m_loaded = 1'b0;
            m_run    = !m_run && pll_locked;
            t        = 0;
        end else begin
            acc    = s_valid && m_ready;
            nt     = t + 1;
            ld     = (nt % C == 0) && ((nt / C) % (2 * S) == 1);
            nready = !m_full && !acc;
            m_fs   = ld;
            m_ur   = ld && !m_full;
            if (ld) begin
                if (m_full) begin
                    m_frame = {m_hl, 8'h00, m_hr, 8'h00};
                end else begin
                    m_frame = '0;
                    if (m_ucnt < 65535) m_ucnt++;
                end
                m_full    = 1'b0;
                m_loaded  = 1'b1;
                m_load_fe = nt / C;
            end
            if (acc) begin
                m_full = 1'b1;
                m_hl   = s_left;
                m_hr   = s_right;
                if (mode == M_FIX) fixed_done = 1'b1;
            end
            m_ready = nready;
            t       = nt;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int guard;
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        s_valid    = 1'b0;
        s_left     = '0;
        s_right    = '0;

        drv_rst = 1'b0;
        drv_pll = 1'b1;
        repeat (6) step();

        drv_rst = 1'b1;
        mode    = M_FIX;
        repeat (400) step();
        chk("fixed_accepted", 32'(fixed_done), 32'd1);
        chk("ucnt_after_underrun", 32'(underrun_cnt), 32'd1);

        mode = M_RAND;
        repeat (4 * FRAME) step();
        mode = M_ALL;
        repeat (2 * FRAME) step();

        mode  = M_RAND;
        guard = 0;
        while (!(m_run && ((t / C) % (2 * S)) == 20) && guard < 1000) begin
            step();
            guard++;
        end
        chk("reach_bc20", 32'(guard < 1000), 32'd1);
        drv_pll = 1'b0;
        repeat (10) step();
        drv_pll = 1'b1;
        repeat (2 * FRAME) step();

        repeat (3) begin
            repeat ($urandom_range(100, 500)) step();
            drv_pll = 1'b0;
            repeat ($urandom_range(1, 20)) step();
            drv_pll = 1'b1;
        end
        repeat (FRAME) step();

        mode    = M_IDLE;
        drv_pll = 1'b0;
        repeat (3) step();
        force dut.urun_cnt_q = 16'hFFFC;
        m_ucnt = 32'hFFFC;
        repeat (2) step();
        release dut.urun_cnt_q;
        drv_pll = 1'b1;
        repeat (6 * FRAME + 20) step();
        chk("ucnt_sat", 32'(underrun_cnt), 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
